mod_mul_pipe: RTL and testbench
===============================

Name: mod_mul_pipe

Overview:
Parametrised, fully pipelined modular multiplier computing r = (a*b) mod Q by Barrett reduction. Defaults target the Kyber field (Q=3329, 12-bit).
Sits between the NTT/butterfly datapath and coefficient memory. It accepts one operand pair per cycle under a valid/ready handshake and carries a sideband tag so callers can match results to requests.
Next generation of the single-cycle-enable multiplier: adds width/modulus parameters, backpressure, flush, tag pass-through and out-of-range detection.

Parameters:
WIDTH, 12, operand/result width in bits
Q, 3329, modulus; must satisfy 1 < Q < 2^WIDTH; elaboration-time check required
TAG_W, 4, sideband tag width carried alongside each operation
(derived, not overridable) K = 2*WIDTH; M = floor(2^K / Q), e.g. 5039 for the defaults

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair this cycle
a  in  WIDTH  operand a
b  in  WIDTH  operand b
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
r  out  WIDTH  result, always in the range [0, Q-1]
out_tag  out  TAG_W  tag of this result
out_err  out  1  a >= Q or b >= Q for this result
busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset: rst_n low asynchronously clears all stage valids, r, out_tag and out_err to 0. Hence out_valid=0 and busy=0. in_ready is 0 while rst_n is low.
- Stall enable: adv = !out_valid || out_ready.
- in_ready = adv && !flush, combinational.
- Transfer at input: in_valid && in_ready. Transfer at output: out_valid && out_ready.
- Pipeline has 3 stages, all advancing together when adv=1 and all holding when adv=0. Bubbles also freeze during a stall; this is accepted.
  - S1: p = a*b, full K bits. Register tag. err1 = (a>=Q)||(b>=Q).
  - S2: qhat = (p*M) >> K. Register p, tag and err.
  - S3: t = p - qhat*Q, computed in K bits. Subtract Q while t >= Q, at most twice; two conditional subtractors in series cover every p < 2^K, including out-of-range operands. Register r, tag, err; out_valid = S3 valid.
- Latency: the result appears on the 3rd rising edge after an input transfer when no stall occurs. Throughput is 1 result/cycle with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, r/out_tag/out_err stay stable and no stage changes.
- Flush: when flush=1 at a rising edge, all stage valids clear; data registers may keep stale values. The input offered in that cycle is not accepted.
  - flush overrides in_valid and a simultaneous output transfer.
  - out_valid=0 and busy=0 from the next cycle.
- Out-of-range operands:
  - err is carried with the result.
  - r still equals (a*b) mod Q, using the full WIDTH-bit values.
  - No other side effect.
- Reset mid-operation: all in-flight results are lost and no partial output is produced.
- busy = S1v || S2v || S3v.
- Widths: no truncation before the final result. The p*M intermediate is K+clog2(M+1) bits; qhat*Q is K bits.

Test Plan:
- rst_n low mid-stream with 3 ops in flight -> out_valid=0, busy=0, r=0 immediately (asynchronous). After release, new a=2,b=3 -> r=6 at cycle 3.
- Single op a=1234,b=2345,tag=5, out_ready=1 -> out_valid on the 3rd edge, r=829, out_tag=5, out_err=0.
- Boundary operands, back to back: (3328,3328)->1, (0,1234)->0, (1,3328)->3328, (3328,2)->3327. Results arrive in order on 4 consecutive cycles with tags preserved.
- Out-of-range a=4095,b=4095 -> r=852, out_err=1. Then a=3329,b=1 -> r=0, out_err=1.
- Backpressure: stream 10 random ops, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the hold, outputs stable, no loss or duplication. Scoreboard matches (a*b)%3329 for all 10.
- Flush with 3 ops in flight and in_valid=1 -> no result emitted for any of the 4. busy=0 next cycle. A following op a=7,b=8 -> r=56.

Source files
------------

// File: rtl/mod_mul_pipe.sv
// Three-stage pipelined Barrett modular multiplier r = (a*b) mod Q with
// valid/ready handshake, flush, tag pass-through and out-of-range flagging.
module mod_mul_pipe #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int             K     = 2 * WIDTH;
    localparam logic [K:0]     TWO_K = {1'b1, {K{1'b0}}};
    localparam logic [K:0]     M_L   = TWO_K / (K+1)'(Q);
    localparam int             MW    = $clog2(M_L + (K+1)'(1));
    localparam int             PW    = K + MW;
    localparam logic [K-1:0]   Q_K   = K'(Q);
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

    generate
        if (Q <= 32'sd1 || longint'(Q) >= (64'sd1 <<< WIDTH)) begin : g_bad_q
            $error("mod_mul_pipe: Q must satisfy 1 < Q < 2**WIDTH");
        end
    endgenerate

    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [K-1:0]     s1_p_q, s2_p_q;
    logic [MW-1:0]    s2_qhat_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
    logic             s1_err_q, s2_err_q, s3_err_q;
    logic [WIDTH-1:0] s3_r_q;

    logic             adv_s;
    logic             s1_v_d;
    logic [K-1:0]     s1_p_d;
    logic             s1_err_d;
    logic [PW-1:0]    pm_s;
    logic [MW-1:0]    s2_qhat_d;
    logic [K-1:0]     qq_s, t0_s, t1_s;
    logic [WIDTH-1:0] s3_r_d;

    assign adv_s     = !s3_v_q || out_ready;
    assign in_ready  = rst_n && adv_s && !flush;
    assign out_valid = s3_v_q;
    assign r         = s3_r_q;
    assign out_tag   = s3_tag_q;
    assign out_err   = s3_err_q;
    assign busy      = s1_v_q || s2_v_q || s3_v_q;

    // Datapath: full product, Barrett quotient estimate, and up to two corrections.
    always_comb begin
        s1_v_d    = in_valid && in_ready;
        s1_p_d    = K'(a) * K'(b);
        s1_err_d  = (a >= Q_W) || (b >= Q_W);
        pm_s      = PW'(s1_p_q) * PW'(M_L);
        s2_qhat_d = MW'(pm_s >> K);
        qq_s      = K'(s2_qhat_q) * Q_K;
        t0_s      = s2_p_q - qq_s;
        if (t0_s >= Q_K) begin
            t1_s = t0_s - Q_K;
        end else begin
            t1_s = t0_s;
        end
        if (t1_s >= Q_K) begin
            s3_r_d = WIDTH'(t1_s - Q_K);
        end else begin
            s3_r_d = WIDTH'(t1_s);
        end
    end

    // Pipeline registers: flush drops valids, a stall freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_p_q    <= '0;
            s2_p_q    <= '0;
            s2_qhat_q <= '0;
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            s3_tag_q  <= '0;
            s1_err_q  <= 1'b0;
            s2_err_q  <= 1'b0;
            s3_err_q  <= 1'b0;
            s3_r_q    <= '0;
        end else if (flush) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
        end else if (adv_s) begin
            s1_v_q    <= s1_v_d;
            s1_p_q    <= s1_p_d;
            s1_tag_q  <= in_tag;
            s1_err_q  <= s1_err_d;
            s2_v_q    <= s1_v_q;
            s2_p_q    <= s1_p_q;
            s2_qhat_q <= s2_qhat_d;
            s2_tag_q  <= s1_tag_q;
            s2_err_q  <= s1_err_q;
            s3_v_q    <= s2_v_q;
            s3_r_q    <= s3_r_d;
            s3_tag_q  <= s2_tag_q;
            s3_err_q  <= s2_err_q;
        end
    end

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Directed bench for mod_mul_pipe: a negedge monitor scores every output
// transfer against a queue of expected results built from the driven inputs.
module tb_mod_mul_pipe;

    localparam int WIDTH = 12;
    localparam int Q     = 3329;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             e_m;
    int               checks = 0;
    int               failures = 0;
    int               n_out = 0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] r_prev = '0;
    logic [TAG_W-1:0] tag_prev = '0;
    logic             err_prev = 1'b0;

    always #5 clk = ~clk;

    mod_mul_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [TAG_W-1:0] t);
        exp_t        e;
        int unsigned p;
        p     = 32'(x) * 32'(y);
        e.r   = WIDTH'(p % 32'(Q));
        e.tag = t;
        e.err = (32'(x) >= 32'(Q)) || (32'(y) >= 32'(Q));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        in_tag   = t;
    endtask

    // Scoreboard monitor, sampling on the falling edge between active edges.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else if (!clk) begin
            if (in_valid && in_ready) sb_q.push_back(model(a, b, in_tag));
            if (flush) begin
                sb_q.delete();
            end else if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'(sb_q.size()), 32'd1);
                end else begin
                    e_m = sb_q.pop_front();
                    chk("sb_r", 32'(r), 32'(e_m.r));
                    chk("sb_tag", 32'(out_tag), 32'(e_m.tag));
                    chk("sb_err", 32'(out_err), 32'(e_m.err));
                end
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (stall_prev) begin
                    chk("stall_r", 32'(r), 32'(r_prev));
                    chk("stall_tag", 32'(out_tag), 32'(tag_prev));
                    chk("stall_err", 32'(out_err), 32'(err_prev));
                end
                stall_prev = 1'b1;
                r_prev     = r;
                tag_prev   = out_tag;
                err_prev   = out_err;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] xs [4];
        logic [WIDTH-1:0] ys [4];
        logic [WIDTH-1:0] es [4];
        logic [WIDTH-1:0] rx, ry;
        int               idx, cyc, n, out_mark;
        logic             pending;

        xs = '{12'd3328, 12'd0, 12'd1, 12'd3328};
        ys = '{12'd3328, 12'd1234, 12'd3328, 12'd2};
        es = '{12'd1, 12'd0, 12'd3328, 12'd3327};

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset with three operations in flight.
        out_ready = 1'b0;
        offer(12'd100, 12'd200, 4'd1); tick();
        offer(12'd300, 12'd400, 4'd2); tick();
        offer(12'd500, 12'd600, 4'd3); tick();
        in_valid = 1'b0;
        chk("mid_full_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_r", 32'(r), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        offer(12'd2, 12'd3, 4'd6); tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_lat2", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_r", 32'(r), 32'd6);
        tick();

        // Single operation latency.
        offer(12'd1234, 12'd2345, 4'd5); tick();
        in_valid = 1'b0;
        chk("single_lat1", 32'(out_valid), 32'd0);
        tick();
        chk("single_lat2", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_r", 32'(r), 32'd829);
        chk("single_tag", 32'(out_tag), 32'd5);
        chk("single_err", 32'(out_err), 32'd0);
        tick();

        // Boundary operands back to back, one result per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) offer(xs[i], ys[i], 4'(i + 8));
            else in_valid = 1'b0;
            tick();
            if (i >= 2) begin
                chk("bnd_valid", 32'(out_valid), 32'd1);
                chk("bnd_r", 32'(r), 32'(es[i-2]));
                chk("bnd_tag", 32'(out_tag), 32'(i + 6));
            end
        end
        tick();

        // Out-of-range operands.
        offer(12'd4095, 12'd4095, 4'd10); tick();
        offer(12'd3329, 12'd1, 4'd11); tick();
        in_valid = 1'b0;
        tick();
        chk("oor1_r", 32'(r), 32'd852);
        chk("oor1_err", 32'(out_err), 32'd1);
        tick();
        chk("oor2_r", 32'(r), 32'd0);
        chk("oor2_err", 32'(out_err), 32'd1);
        tick();

        // Random stream with a five-cycle output stall.
        out_mark = n_out;
        idx      = 0;
        cyc      = 0;
        pending  = 1'b0;
        rx       = '0;
        ry       = '0;
        while (idx < 10 && cyc < 100) begin
            out_ready = !(cyc >= 5 && cyc < 10);
            if (!pending) begin
                rx      = WIDTH'($urandom_range(0, Q - 1));
                ry      = WIDTH'($urandom_range(0, Q - 1));
                pending = 1'b1;
            end
            offer(rx, ry, 4'(idx));
            #1;
            if (cyc >= 5 && cyc < 10) chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (in_ready) begin
                idx++;
                pending = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_accepted", 32'(idx), 32'd10);
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_drain", 32'(sb_q.size()), 32'd0);
        chk("bp_count", 32'(n_out - out_mark), 32'd10);
        tick();
        tick();

        // Flush with three in flight plus one offered.
        out_ready = 1'b0;
        offer(12'd11, 12'd12, 4'd1); tick();
        offer(12'd13, 12'd14, 4'd2); tick();
        offer(12'd15, 12'd16, 4'd3); tick();
        offer(12'd17, 12'd18, 4'd4);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        out_mark  = n_out;
        for (int i = 0; i < 4; i++) tick();
        chk("flush_no_out", 32'(n_out - out_mark), 32'd0);
        chk("flush_still_idle", 32'(busy), 32'd0);
        offer(12'd7, 12'd8, 4'd9); tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("after_flush_valid", 32'(out_valid), 32'd1);
        chk("after_flush_r", 32'(r), 32'd56);
        tick();
        tick();
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
